il_bank_scheduler: RTL

Ping-pong bank scheduler for the turbo-code interleaver datapath. It accepts CRC-delimited code blocks of two sizes and alternates them between interleaver RAM bank 0 and bank 1. It fills one bank with linear write addresses while draining the other with linear read addresses, which the downstream pi tables permute. It also owns bank occupancy, block-size bookkeeping, input backpressure, and output framing (data_ready/done).

---
 rtl/il_bank_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/il_bank_scheduler.sv
// il_bank_scheduler
// Ping-pong bank scheduler for the turbo-code interleaver. Incoming code
// blocks of two sizes fill interleaver RAM bank 0 and bank 1 alternately,
// using linear write addresses. Each full bank is then drained with linear
// read addresses, and the downstream pi tables permute them.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   CRC_start             first bit of a block is present this cycle
//   CRC_blocksize         block size (0: SMALL_K, 1: LARGE_K), taken with an accepted start
//   data_valid            one input bit is present this cycle
//   in_ready              the current write bank is empty and a new block may start
//   wr_en/wr_bank/wr_addr/wr_size   write strobe, bank, linear index, block size
//   rd_en/rd_bank/rd_addr/rd_size   read strobe, bank, linear index, block size
//   data_ready            RAM read data valid (rd_en delayed by one cycle)
//   done                  pulse that comes with the last data_ready of a block
//   drop_err              pulse: a CRC_start arrived that could not be accepted
//   bank_full[1:0]        per bank, FULL or DRAINING
module il_bank_scheduler #(
    parameter int SMALL_K = 1056,
    parameter int LARGE_K = 6144,
    parameter int AW      = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          CRC_start,
    input  logic          CRC_blocksize,
    input  logic          data_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          wr_size,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          rd_size,
    output logic          data_ready,
    output logic          done,
    output logic          drop_err,
    output logic [1:0]    bank_full
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

    localparam logic [AW-1:0] SMALL_LAST = AW'(SMALL_K - 1);
    localparam logic [AW-1:0] LARGE_LAST = AW'(LARGE_K - 1);

    function automatic logic [AW-1:0] last_index(input logic size);
        return size ? LARGE_LAST : SMALL_LAST;
    endfunction

    w_state_t      w_state_reg, w_state_next;
    r_state_t      r_state_reg, r_state_next;
    logic          wptr_reg, wptr_next;
    logic          rptr_reg, rptr_next;
    logic [AW-1:0] wcnt_reg, wcnt_next;
    logic [AW-1:0] rcnt_reg, rcnt_next;
    // Last address and size driven, so the outputs can hold them while idle.
    logic [AW-1:0] wr_addr_reg, rd_addr_reg;
    logic          wr_size_reg, rd_size_reg;
    logic          data_ready_reg, done_reg;

    // Bank transition events, raised by the two FSMs for bank[wptr]/bank[rptr].
    logic          w_start, w_last, r_start, r_last;
    logic [1:0]    bank_empty, bank_ready, bank_size;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            bank_state_t state_reg;
            logic        size_reg;

            // The writer only touches EMPTY/FILLING banks and the reader only
            // touches FULL/DRAINING banks, so at most one event hits a bank per cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= B_EMPTY;
                    size_reg  <= 1'b0;
                end else if (w_start && wptr_reg == 1'(gi)) begin
                    state_reg <= B_FILLING;
                    size_reg  <= CRC_blocksize;
                end else if (w_last && wptr_reg == 1'(gi)) begin
                    state_reg <= B_FULL;
                end else if (r_start && rptr_reg == 1'(gi)) begin
                    state_reg <= B_DRAINING;
                end else if (r_last && rptr_reg == 1'(gi)) begin
                    state_reg <= B_EMPTY;
                end
            end

            assign bank_empty[gi] = (state_reg == B_EMPTY);
            assign bank_ready[gi] = (state_reg == B_FULL);
            assign bank_full[gi]  = (state_reg == B_FULL) || (state_reg == B_DRAINING);
            assign bank_size[gi]  = size_reg;
        end
    endgenerate

    // Write side: the accepting cycle already writes address 0.
    always_comb begin
        w_state_next = w_state_reg;
        wptr_next    = wptr_reg;
        wcnt_next    = wcnt_reg;
        in_ready     = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = wr_addr_reg;
        wr_size      = wr_size_reg;
        w_start      = 1'b0;
        w_last       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                in_ready = bank_empty[wptr_reg];
                if (CRC_start && bank_empty[wptr_reg]) begin
                    w_start      = 1'b1;
                    wr_en        = 1'b1;
                    wr_addr      = '0;
                    wr_size      = CRC_blocksize;
                    wcnt_next    = AW'(1);
                    w_state_next = W_FILL;
                end
            end
            W_FILL: begin
                wr_en   = data_valid;
                wr_addr = wcnt_reg;
                wr_size = bank_size[wptr_reg];
                if (data_valid) begin
                    if (wcnt_reg == last_index(bank_size[wptr_reg])) begin
                        w_last       = 1'b1;
                        wcnt_next    = '0;
                        wptr_next    = ~wptr_reg;
                        w_state_next = W_IDLE;
                    end else begin
                        wcnt_next = wcnt_reg + AW'(1);
                    end
                end
            end
        endcase
        // in_ready is low throughout W_FILL, so this also covers a start mid-block.
        drop_err = CRC_start && !in_ready;
    end

    // Read side: the cycle that sees a FULL bank reads address 0, so
    // back-to-back full banks drain without a gap.
    always_comb begin
        r_state_next = r_state_reg;
        rptr_next    = rptr_reg;
        rcnt_next    = rcnt_reg;
        rd_en        = 1'b0;
        rd_addr      = rd_addr_reg;
        rd_size      = rd_size_reg;
        r_start      = 1'b0;
        r_last       = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (bank_ready[rptr_reg]) begin
                    r_start      = 1'b1;
                    rd_en        = 1'b1;
                    rd_addr      = '0;
                    rd_size      = bank_size[rptr_reg];
                    rcnt_next    = AW'(1);
                    r_state_next = R_DRAIN;
                end
            end
            R_DRAIN: begin
                rd_en   = 1'b1;
                rd_addr = rcnt_reg;
                rd_size = bank_size[rptr_reg];
                if (rcnt_reg == last_index(bank_size[rptr_reg])) begin
                    r_last       = 1'b1;
                    rcnt_next    = '0;
                    rptr_next    = ~rptr_reg;
                    r_state_next = R_IDLE;
                end else begin
                    rcnt_next = rcnt_reg + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_reg    <= W_IDLE;
            r_state_reg    <= R_IDLE;
            wptr_reg       <= 1'b0;
            rptr_reg       <= 1'b0;
            wcnt_reg       <= '0;
            rcnt_reg       <= '0;
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            wr_size_reg    <= 1'b0;
            rd_size_reg    <= 1'b0;
            data_ready_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            w_state_reg    <= w_state_next;
            r_state_reg    <= r_state_next;
            wptr_reg       <= wptr_next;
            rptr_reg       <= rptr_next;
            wcnt_reg       <= wcnt_next;
            rcnt_reg       <= rcnt_next;
            wr_addr_reg    <= wr_addr;
            rd_addr_reg    <= rd_addr;
            wr_size_reg    <= wr_size;
            rd_size_reg    <= rd_size;
            data_ready_reg <= rd_en;
            done_reg       <= r_last;
        end
    end

    assign wr_bank    = wptr_reg;
    assign rd_bank    = rptr_reg;
    assign data_ready = data_ready_reg;
    assign done       = done_reg;

endmodule
